// File: rtl/led_pwm_pkg.sv
// Shared types and constants for the PWM duty meter.
package led_pwm_pkg;

  localparam int unsigned DEF_WIDTH = 12;
  localparam int unsigned DUTY_FULL = 1 << DEF_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALIGN   = 2'd1,
    MEASURE = 2'd2
  } meter_state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// PWM input conditioning: synchronizer, optional 3-sample majority filter
// (PWM_GLITCH_FILTER_EN) and rising-edge detect.
module pwm_in_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

`ifdef PWM_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;
  logic       sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Majority of the last three synchronized samples; single-cycle blips vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync_s};
      filt_q <= (sync_s & hist_q[0]) | (sync_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign s = filt_q;
`else
  assign s = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_d <= 1'b0;
    else        s_d <= s;
  end

  assign rise = s & ~s_d;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures PWM high time over 2^WIDTH-cycle frames aligned to a rising edge;
// reports constant levels as static. PWM_GLITCH_FILTER_EN enables input filtering.
module pwm_duty_meter
  import led_pwm_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           pwm_in,
  output logic [WIDTH:0] duty,
  output logic           duty_valid,
  output logic           is_static,
  output logic           busy
);

  localparam logic [WIDTH:0]   FULL_V  = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] WIN_MAX = {WIDTH{1'b1}};

  logic s;
  logic rise;

  pwm_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise)
  );

  meter_state_e     state, state_n;
  logic [WIDTH-1:0] win_cnt, win_n;
  logic [WIDTH:0]   high_cnt, high_n;
  logic [WIDTH:0]   duty_n;
  logic             valid_n;
  logic             static_n;

  // Next-state and report logic; dropping en discards any frame in progress.
  always_comb begin
    state_n  = state;
    win_n    = win_cnt;
    high_n   = high_cnt;
    duty_n   = duty;
    static_n = is_static;
    valid_n  = 1'b0;
    if (!en) begin
      state_n = IDLE;
      win_n   = '0;
      high_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = ALIGN;
          win_n   = '0;
          high_n  = '0;
        end
        ALIGN: begin
          if (rise) begin
            state_n = MEASURE;
            win_n   = WIDTH'(1);
            high_n  = (WIDTH+1)'(1);
          end else if (win_cnt == WIN_MAX) begin
            duty_n   = s ? FULL_V : '0;
            static_n = 1'b1;
            valid_n  = 1'b1;
            win_n    = '0;
          end else begin
            win_n = win_cnt + WIDTH'(1);
          end
        end
        MEASURE: begin
          if (win_cnt == WIN_MAX) begin
            duty_n   = high_cnt + (WIDTH+1)'(s);
            static_n = 1'b0;
            valid_n  = 1'b1;
            state_n  = ALIGN;
            win_n    = '0;
            high_n   = '0;
          end else begin
            high_n = high_cnt + (WIDTH+1)'(s);
            win_n  = win_cnt + WIDTH'(1);
          end
        end
        default: begin
          state_n = IDLE;
          win_n   = '0;
          high_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      win_cnt    <= '0;
      high_cnt   <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      is_static  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      win_cnt    <= win_n;
      high_cnt   <= high_n;
      duty       <= duty_n;
      duty_valid <= valid_n;
      is_static  <= static_n;
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Self-checking bench for pwm_duty_meter: frame-level reference model over the
// recorded input history, plus directed checks of reset, hold and static behaviour.
`timescale 1ns/1ps
module tb_pwm_duty_meter;
  import led_pwm_pkg::*;

  localparam int W    = 12;
  localparam int S    = 2;
  localparam int FULL = 1 << W;
  localparam int MAXE = 120000;

  typedef struct {
    int edge_n;
    int duty;
    int stat;
  } rep_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       pwm_in;
  logic [W:0] duty;
  logic       duty_valid;
  logic       is_static;
  logic       busy;

  pwm_duty_meter #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .duty_valid (duty_valid),
    .is_static  (is_static),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  bit   pin [MAXE];
  bit   ena [MAXE];
  int   n = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   glitch_en = 1'b0;
  rep_t obs_q[$];
  rep_t exp_q[$];

  task automatic check(input string tag, input int got, input int expv);
    tests_run++;
    if (got !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Drive inputs for the next rising edge, then sample outputs on the falling edge.
  task automatic step(input bit p, input bit e);
    rep_t r;
    if (n + 1 >= MAXE) begin
      $display("FAIL cycle_budget: got %0d expected <%0d", n + 1, MAXE);
      $fatal(1, "cycle budget exhausted");
    end
    pwm_in = p;
    en     = e;
    pin[n+1] = p;
    ena[n+1] = e && rst_n;
    @(posedge clk);
    n++;
    @(negedge clk);
    if (duty_valid) begin
      r.edge_n = n;
      r.duty   = int'(duty);
      r.stat   = int'(is_static);
      obs_q.push_back(r);
    end
  endtask

  task automatic run_pwm(input int cycles, input int per, input int hi, input bit e,
                         input bit stop_on_valid, output bit hit);
    bit p;
    int q0;
    hit = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      p = ((n + 1) % per) < hi;
      if (glitch_en && $urandom_range(0, 511) == 0) p = ~p;
      q0 = obs_q.size();
      step(p, e);
      if (stop_on_valid && obs_q.size() != q0) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  function automatic bit pv(int k);
    return (k >= 1 && k < MAXE) ? pin[k] : 1'b0;
  endfunction

  // Level the meter acts on at edge m, derived from the raw line history.
  function automatic bit vs(int m);
`ifdef PWM_GLITCH_FILTER_EN
    int c;
    c = int'(pv(m - S - 1)) + int'(pv(m - S - 2)) + int'(pv(m - S - 3));
    return c >= 2;
`else
    return pv(m - S);
`endif
  endfunction

  // Frame-level model: align to the first rise within a window, measure a full
  // frame from it, or report the line level on a window with no rise.
  function automatic void build_expected();
    int   m, a, k, r, lim, fin, sum;
    bit   aborted;
    rep_t e;
    m = 1;
    while (m <= n) begin
      if (!ena[m]) begin
        m++;
        continue;
      end
      a = m + 1;
      aborted = 1'b0;
      while (!aborted) begin
        lim = a + FULL - 1;
        r = -1;
        for (k = a; k <= lim; k++) begin
          if (k > n) return;
          if (!ena[k]) break;
          if (vs(k) && !vs(k - 1)) begin
            r = k;
            break;
          end
        end
        if (k <= lim && !ena[k]) begin
          m = k + 1;
          aborted = 1'b1;
        end else if (r < 0) begin
          e.edge_n = lim;
          e.duty   = vs(lim) ? FULL : 0;
          e.stat   = 1;
          exp_q.push_back(e);
          a = lim + 1;
        end else begin
          fin = r + FULL - 1;
          sum = 0;
          for (k = r; k <= fin; k++) begin
            if (k > n) return;
            if (!ena[k]) break;
            sum += int'(vs(k));
          end
          if (k <= fin) begin
            m = k + 1;
            aborted = 1'b1;
          end else begin
            e.edge_n = fin;
            e.duty   = sum;
            e.stat   = 0;
            exp_q.push_back(e);
            a = fin + 1;
          end
        end
      end
    end
  endfunction

  initial begin
    bit hit;
    int nrep;
    rst_n  = 1'b0;
    en     = 1'b0;
    pwm_in = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    check("rst_duty", int'(duty), 0);
    check("rst_valid", int'(duty_valid), 0);
    check("rst_static", int'(is_static), 0);
    check("rst_busy", int'(busy), 0);

    run_pwm(9000, FULL, 95, 1'b1, 1'b0, hit);
    check("dimmer95_duty", int'(duty), 95);
    check("dimmer95_static", int'(is_static), 0);
    check("dimmer95_busy", int'(busy), 1);

    run_pwm(8300, 1, 1, 1'b1, 1'b0, hit);
    check("high_duty", int'(duty), FULL);
    check("high_static", int'(is_static), 1);

    run_pwm(8300, 1, 0, 1'b1, 1'b0, hit);
    check("low_duty", int'(duty), 0);
    check("low_static", int'(is_static), 1);

    run_pwm(9000, FULL, FULL / 2, 1'b1, 1'b0, hit);
    check("half_duty", int'(duty), FULL / 2);
    check("half_static", int'(is_static), 0);

    // Abort a frame mid-measurement by dropping en for 10 cycles.
    run_pwm(FULL + 200, FULL, FULL / 2, 1'b1, 1'b1, hit);
    check("wait_valid_abort", int'(hit), 1);
    run_pwm(2000, FULL, FULL / 2, 1'b1, 1'b0, hit);
    run_pwm(10, FULL, FULL / 2, 1'b0, 1'b0, hit);
    check("drop_busy", int'(busy), 0);
    check("drop_duty_hold", int'(duty), FULL / 2);
    check("drop_static_hold", int'(is_static), 0);
    run_pwm(9000, FULL, FULL / 2, 1'b1, 1'b0, hit);
    check("resume_duty", int'(duty), FULL / 2);

    // Asynchronous reset in the middle of a measured frame.
    run_pwm(FULL + 200, FULL, FULL / 2, 1'b1, 1'b1, hit);
    check("wait_valid_reset", int'(hit), 1);
    run_pwm(2000, FULL, FULL / 2, 1'b1, 1'b0, hit);
    pwm_in = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_rst_duty", int'(duty), 0);
    check("async_rst_valid", int'(duty_valid), 0);
    check("async_rst_static", int'(is_static), 0);
    check("async_rst_busy", int'(busy), 0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_duty", int'(duty), 0);

    run_pwm(8500, FULL, 1, 1'b1, 1'b0, hit);
`ifdef PWM_GLITCH_FILTER_EN
    check("pulse1_duty", int'(duty), 0);
    check("pulse1_static", int'(is_static), 1);
`else
    check("pulse1_duty", int'(duty), 1);
    check("pulse1_static", int'(is_static), 0);
`endif

    glitch_en = 1'b1;
    for (int seg = 0; seg < 3; seg++) begin
      int per;
      int hi;
      per = $urandom_range(64, FULL);
      hi  = $urandom_range(0, per);
      run_pwm(3500, per, hi, 1'b1, 1'b0, hit);
    end
    glitch_en = 1'b0;

    build_expected();
    check("report_count", obs_q.size(), exp_q.size());
    nrep = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nrep; i++) begin
      check($sformatf("rep%0d_edge", i), obs_q[i].edge_n, exp_q[i].edge_n);
      check($sformatf("rep%0d_duty", i), obs_q[i].duty, exp_q[i].duty);
      check($sformatf("rep%0d_static", i), obs_q[i].stat, exp_q[i].stat);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
